// File: rtl/iob_ram_dp_arb_pkg.sv
// Shared types and helpers for the dual-port RAM arbiter.
// The pointer width is a function because the requester count is a parameter of the top.
package iob_ram_dp_arb_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } portSel_e;

  function automatic int ptrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_rr_pick.sv
// Rotating find-first-set: returns the first set bit of mask when scanning
// ptr, ptr+1, ... modulo N.
module iob_rr_pick
  import iob_ram_dp_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = ptrWidth(N)
) (
  input  logic [N-1:0]     mask,
  input  logic [PTR_W-1:0] ptr,
  output logic             found,
  output logic [PTR_W-1:0] idx
);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [PTR_W:0] sum;

  // Rotating by shifting a doubled copy keeps the scan free of variable bit selects.
  assign doubled = {mask, mask};
  assign rotated = N'(doubled >> ptr);

  always_comb begin
    found = 1'b0;
    sum   = '0;
    // Descending loop so the lowest rotated position wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (PTR_W + 1)'(k);
      end
    end
    idx = (sum >= (PTR_W + 1)'(N)) ? PTR_W'(sum - (PTR_W + 1)'(N)) : sum[PTR_W-1:0];
  end

endmodule

// File: rtl/iob_ram_dp_arb.sv
// Round-robin arbiter sharing one dual-port RAM among N_REQ requesters:
// up to two grants per cycle, same-address hazards blocked, read data routed back.
module iob_ram_dp_arb
  import iob_ram_dp_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [N_REQ*DATA_W-1:0]   rsp_data,
  output logic                      ram_enA,
  output logic                      ram_weA,
  output logic [ADDR_W-1:0]         ram_addrA,
  output logic [DATA_W-1:0]         ram_dinA,
  input  logic [DATA_W-1:0]         ram_doutA,
  output logic                      ram_enB,
  output logic                      ram_weB,
  output logic [ADDR_W-1:0]         ram_addrB,
  output logic [DATA_W-1:0]         ram_dinB,
  input  logic [DATA_W-1:0]         ram_doutB
);

  localparam int PTR_W = ptrWidth(N_REQ);

  function automatic logic [PTR_W-1:0] nextIdx(input logic [PTR_W-1:0] x);
    return (x == PTR_W'(N_REQ - 1)) ? '0 : x + PTR_W'(1);
  endfunction

  logic [ADDR_W-1:0] addrArr  [N_REQ];
  logic [DATA_W-1:0] wdataArr [N_REQ];

  logic              foundA, foundB, grantA, grantB;
  logic [PTR_W-1:0]  idxA, idxB, ptrB;
  logic [PTR_W-1:0]  rrPtrReg, rrPtrNext;
  logic              weSelA, weSelB;
  logic [ADDR_W-1:0] addrSelA;
  logic [N_REQ-1:0]  conflict, maskB, oneHotA, oneHotB;
  logic [N_REQ-1:0]  rspValidReg, rspValidNext;
  portSel_e          rspSelReg  [N_REQ];
  portSel_e          rspSelNext [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addrArr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdataArr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  iob_rr_pick #(.N(N_REQ), .PTR_W(PTR_W)) pickA (
    .mask  (req_valid),
    .ptr   (rrPtrReg),
    .found (foundA),
    .idx   (idxA)
  );

  assign addrSelA = addrArr[idxA];
  assign weSelA   = req_we[idxA];
  assign oneHotA  = N_REQ'(1) << idxA;
  assign ptrB     = nextIdx(idxA);

  // Two reads of one address may share a cycle; anything involving a write may not.
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_conflict
      assign conflict[gi] = (addrArr[gi] == addrSelA) && (weSelA || req_we[gi]);
    end
  endgenerate

  assign maskB = req_valid & ~conflict & ~oneHotA;

  iob_rr_pick #(.N(N_REQ), .PTR_W(PTR_W)) pickB (
    .mask  (maskB),
    .ptr   (ptrB),
    .found (foundB),
    .idx   (idxB)
  );

  assign weSelB  = req_we[idxB];
  assign oneHotB = N_REQ'(1) << idxB;
  assign grantA  = foundA & ~rst;
  assign grantB  = foundB & ~rst;

  assign req_ready = ({N_REQ{grantA}} & oneHotA) | ({N_REQ{grantB}} & oneHotB);

  assign ram_enA   = grantA;
  assign ram_weA   = grantA & weSelA;
  assign ram_addrA = addrSelA;
  assign ram_dinA  = wdataArr[idxA];
  assign ram_enB   = grantB;
  assign ram_weB   = grantB & weSelB;
  assign ram_addrB = addrArr[idxB];
  assign ram_dinB  = wdataArr[idxB];

  always_comb begin
    rrPtrNext = rrPtrReg;
    if (grantB) begin
      rrPtrNext = nextIdx(idxB);
    end else if (grantA) begin
      rrPtrNext = nextIdx(idxA);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtrReg <= '0;
    end else begin
      rrPtrReg <= rrPtrNext;
    end
  end

  // Per-requester response tracking: one pulse per granted read, tagged with its port.
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rsp
      assign rspValidNext[gi] = (grantA && (idxA == PTR_W'(gi)) && !weSelA) ||
                                (grantB && (idxB == PTR_W'(gi)) && !weSelB);
      assign rspSelNext[gi]   = (grantB && (idxB == PTR_W'(gi))) ? PORT_B : PORT_A;

      always_ff @(posedge clk) begin
        if (rst) begin
          rspValidReg[gi] <= 1'b0;
          rspSelReg[gi]   <= PORT_A;
        end else begin
          rspValidReg[gi] <= rspValidNext[gi];
          rspSelReg[gi]   <= rspSelNext[gi];
        end
      end

      // Reset in the return cycle drops the response outright.
      assign rsp_valid[gi] = rspValidReg[gi] & ~rst;
      assign rsp_data[gi*DATA_W +: DATA_W] =
        !rsp_valid[gi]           ? '0 :
        (rspSelReg[gi] == PORT_B) ? ram_doutB : ram_doutA;
    end
  endgenerate

endmodule

// File: doc/iob_ram_dp_arb.md
Name: iob_ram_dp_arb

Overview:
- Round-robin arbiter that shares one dual-port RAM between N_REQ requesters.
- Grants up to two requests per cycle, one on RAM port A and one on port B.
- Blocks same-address conflicts and routes read data back to the requester that issued the read.
- Sits between accelerator functional units and the dual-port RAM primitive; the RAM itself is instantiated outside this block.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, RAM data width
ADDR_W, 6, RAM address width

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  N_REQ  request i valid
req_we  in  N_REQ  request i is a write (1) or read (0)
req_addr  in  N_REQ*ADDR_W  address of request i, slice i
req_wdata  in  N_REQ*DATA_W  write data of request i, slice i
req_ready  out  N_REQ  grant; request i accepted when valid&ready
rsp_valid  out  N_REQ  read data for requester i valid this cycle
rsp_data  out  N_REQ*DATA_W  read data slice i
ram_enA/ram_weA  out  1 each  RAM port A enable / write enable
ram_addrA  out  ADDR_W  RAM port A address
ram_dinA  out  DATA_W  RAM port A write data
ram_doutA  in  DATA_W  RAM port A read data (1-cycle latency)
ram_enB, ram_weB, ram_addrB, ram_dinB, ram_doutB: same as port A, for port B

Behaviour:
- Reset (rst=1 at clock edge): rr_ptr=0, rsp_valid=0, tracking registers cleared.
- During rst, req_ready=0 and ram_enA=ram_enB=0 combinationally, so nothing is accepted.
- Grant is combinational from req_valid, req_we, req_addr and rr_ptr; requesters must not make req_valid depend on req_ready.
- Pick A: first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ. It drives port A: enA=1, weA=req_we[i], addr, wdata.
- Pick B: next valid j after A in the same scan order whose access does not conflict with A. It drives port B.
- Conflict: addr_j == addr_A and (we_A or we_j). Two reads to the same address do not conflict.
- A conflicting requester is skipped that cycle; the scan continues to later requesters.
- req_ready[i]=1 only for granted requesters; at most 2 bits set.
- With no valid request, port A and port B enables stay 0. With one grantable request, port B stays idle.
- rr_ptr update at the clock edge: index after the last granted requester (B if granted, else A), modulo N_REQ. Unchanged when nothing is granted.
- Read return latency is 1 cycle. For each granted read, a registered rsp_valid[i]=1 is set in the following cycle, together with a registered port-select bit for i.
- rsp_data slice i = ram_doutA if the select bit is A, else ram_doutB (mux on the RAM outputs). Slices with rsp_valid=0 are don't-care; drive 0.
- Write grants produce no rsp_valid.
- A requester granted in consecutive cycles gets back-to-back rsp_valid pulses.
- Reset asserted in the cycle after a read grant: rsp_valid is forced 0 and the response is dropped.
- Throughput: 2 accesses/cycle when at least 2 non-conflicting requests are pending.
- Starvation-free: a requester held continuously valid is granted within N_REQ cycles.

Decomposition:
- Package iob_ram_dp_arb_pkg: localparam PTR_W = $clog2(N_REQ); port-select encoding PORT_A=0, PORT_B=1.
- Sub-module iob_rr_pick: find-first-set in a request mask rotated by a pointer. Outputs found flag and index.
- Instantiate it twice: once for port A; once for port B with the mask excluding A and conflicting requesters, and the pointer set to A+1.

Test Plan:
- Reset, then all req_valid=0 → req_ready=0, ram_enA=ram_enB=0, rsp_valid=0 every cycle.
- Req0 write addr 5 data 0xAA, then next cycle req1 read addr 5 → cycle 1 ready0=1, weA=1, addrA=5. Cycle 2 ready1=1 on port A. Cycle 3 rsp_valid=0b0010, rsp_data slice1=0xAA.
- All 4 requesters read distinct addrs continuously → 2 grants/cycle, pattern {0,1},{2,3},{0,1}... Each requester sees rsp_valid every 2nd cycle.
- Req0 write addr 9, req1 read addr 9, req2 read addr 3, rr_ptr=0 → grant 0 on A, 2 on B, 1 blocked. Next cycle rr_ptr=3 and req1 is granted.
- Req1 and req2 both read addr 7 (value 0x5C) in the same cycle → both granted (A and B). Next cycle rsp_valid=0b0110, both slices=0x5C.
- Read granted to req3, rst asserted the following cycle → rsp_valid stays 0 and rr_ptr=0 after reset.
